// File: rtl/aes_pkg.sv
// Shared AES widths, scheduler state encoding and GF(2^8) helper.
package aes_pkg;

  localparam int unsigned AES_STATE_W = 128;
  localparam int unsigned AES_COL_W   = 32;
  localparam int unsigned AES_NCOLS   = 4;
  localparam int unsigned AES_BYTE_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [1:0] col_idx_t;

  // Multiply by x in GF(2^8) modulo 0x11B.
  function automatic logic [AES_BYTE_W-1:0] gf_xtime(input logic [AES_BYTE_W-1:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/gf_mul_lut.sv
// Constant GF(2^8) multiplier (x9/x11/x13/x14), folds to a 256-entry table.
module gf_mul_lut
  import aes_pkg::*;
#(
  parameter logic [3:0] MULT = 4'd9
) (
  input  logic [AES_BYTE_W-1:0] a_i,
  output logic [AES_BYTE_W-1:0] p_o
);

  logic [AES_BYTE_W-1:0] x2, x4, x8;

  // Sum of the powers-of-x terms selected by the constant's bits.
  always_comb begin
    x2  = gf_xtime(a_i);
    x4  = gf_xtime(x2);
    x8  = gf_xtime(x4);
    p_o = (MULT[0] ? a_i : 8'h00) ^
          (MULT[1] ? x2  : 8'h00) ^
          (MULT[2] ? x4  : 8'h00) ^
          (MULT[3] ? x8  : 8'h00);
  end

endmodule

// File: rtl/inv_mix_col.sv
// Combinational single-column InvMixColumns engine; byte a0 is col_i[31:24].
module inv_mix_col
  import aes_pkg::*;
(
  input  logic [AES_COL_W-1:0] col_i,
  output logic [AES_COL_W-1:0] col_o
);

  logic [AES_BYTE_W-1:0] a   [4];
  logic [AES_BYTE_W-1:0] m9  [4];
  logic [AES_BYTE_W-1:0] m11 [4];
  logic [AES_BYTE_W-1:0] m13 [4];
  logic [AES_BYTE_W-1:0] m14 [4];

  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign a[i] = col_i[AES_COL_W-1-AES_BYTE_W*i -: AES_BYTE_W];
    gf_mul_lut #(.MULT(4'd9))  u_m9  (.a_i(a[i]), .p_o(m9[i]));
    gf_mul_lut #(.MULT(4'd11)) u_m11 (.a_i(a[i]), .p_o(m11[i]));
    gf_mul_lut #(.MULT(4'd13)) u_m13 (.a_i(a[i]), .p_o(m13[i]));
    gf_mul_lut #(.MULT(4'd14)) u_m14 (.a_i(a[i]), .p_o(m14[i]));
  end

  // Circulant matrix {14,11,13,9}.
  always_comb begin
    col_o[31:24] = m14[0] ^ m11[1] ^ m13[2] ^ m9[3];
    col_o[23:16] = m9[0]  ^ m14[1] ^ m11[2] ^ m13[3];
    col_o[15:8]  = m13[0] ^ m9[1]  ^ m14[2] ^ m11[3];
    col_o[7:0]   = m11[0] ^ m13[1] ^ m9[2]  ^ m14[3];
  end

endmodule

// File: rtl/inv_mix_cols_sched.sv
// InvMixColumns sequencer: one shared column engine, one column per cycle.
// Optional final-round pass-through enabled by macro INV_MIX_SCHED_BYPASS_EN.
module inv_mix_cols_sched
  import aes_pkg::*;
#(
  parameter bit COL_MSB_FIRST = 1'b1,
  parameter bit LUT_REG       = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_state,
`ifdef INV_MIX_SCHED_BYPASS_EN
  input  logic                   in_bypass,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_state,
  output logic                   busy
);

  state_e                 state_q, state_d;
  col_idx_t               col_cnt_q, col_cnt_d;
  logic [AES_STATE_W-1:0] in_q, in_d;
  logic [AES_STATE_W-1:0] res_q, res_d;
  logic [AES_STATE_W-1:0] out_state_q, out_state_d;
  logic                   out_valid_q, out_valid_d;
  logic [AES_COL_W-1:0]   lut_q;
  col_idx_t               lut_idx_q;
  logic                   lut_vld_q, lut_vld_d;
`ifdef INV_MIX_SCHED_BYPASS_EN
  logic                   bypass_q, bypass_d;
`endif

  logic [AES_COL_W-1:0]   col_in, eng_out, col_res, wr_data;
  logic                   wr_vld, wr_last, accept;
  col_idx_t               wr_idx;

  // Bit offset of a column within the 128-bit state (32 bits per column).
  function automatic logic [6:0] col_lsb(input col_idx_t idx);
    col_idx_t pos;
    pos = COL_MSB_FIRST ? ~idx : idx;
    return {pos, 5'd0};
  endfunction

  inv_mix_col u_col (.col_i(col_in), .col_o(eng_out));

  // Column mux, optional bypass and the write port (direct or via LUT stage).
  always_comb begin
    col_in  = in_q[col_lsb(col_cnt_q) +: AES_COL_W];
`ifdef INV_MIX_SCHED_BYPASS_EN
    col_res = bypass_q ? col_in : eng_out;
`else
    col_res = eng_out;
`endif
    wr_vld    = LUT_REG ? lut_vld_q : (state_q == BUSY);
    wr_idx    = LUT_REG ? lut_idx_q : col_cnt_q;
    wr_data   = LUT_REG ? lut_q     : col_res;
    wr_last   = wr_vld && (wr_idx == 2'd3);
    lut_vld_d = (state_q == BUSY) && !wr_last;
    in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    accept    = in_valid && in_ready;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    col_cnt_d   = col_cnt_q;
    in_d        = in_q;
    res_d       = res_q;
    out_state_d = out_state_q;
    out_valid_d = out_valid_q;
`ifdef INV_MIX_SCHED_BYPASS_EN
    bypass_d    = bypass_q;
`endif

    if (wr_vld) begin
      res_d[col_lsb(wr_idx) +: AES_COL_W] = wr_data;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          in_d      = in_state;
          col_cnt_d = 2'd0;
          state_d   = BUSY;
`ifdef INV_MIX_SCHED_BYPASS_EN
          bypass_d  = in_bypass;
`endif
        end
      end
      BUSY: begin
        col_cnt_d = col_cnt_q + 2'd1;
        if (wr_last) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_state_d = res_d;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
          if (accept) begin
            in_d      = in_state;
            col_cnt_d = 2'd0;
            state_d   = BUSY;
`ifdef INV_MIX_SCHED_BYPASS_EN
            bypass_d  = in_bypass;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      col_cnt_q   <= 2'd0;
      in_q        <= '0;
      res_q       <= '0;
      out_state_q <= '0;
      out_valid_q <= 1'b0;
      lut_q       <= '0;
      lut_idx_q   <= 2'd0;
      lut_vld_q   <= 1'b0;
`ifdef INV_MIX_SCHED_BYPASS_EN
      bypass_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      col_cnt_q   <= col_cnt_d;
      in_q        <= in_d;
      res_q       <= res_d;
      out_state_q <= out_state_d;
      out_valid_q <= out_valid_d;
      lut_q       <= col_res;
      lut_idx_q   <= col_cnt_q;
      lut_vld_q   <= lut_vld_d;
`ifdef INV_MIX_SCHED_BYPASS_EN
      bypass_q    <= bypass_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_state = out_state_q;
  assign busy      = (state_q == BUSY);

endmodule

// File: tb/tb_inv_mix_cols_sched.sv
// Directed bench for inv_mix_cols_sched (default build: LUT_REG=0).
module tb_inv_mix_cols_sched;

  localparam int EXP_LAT = 4;
  localparam int TMO     = 40;

  localparam logic [127:0] V1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] E1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V2 = 128'h4d7ebdf8_d5d5d7d6_00000000_ffffffff;
  localparam logic [127:0] E2 = 128'h2d26314c_d4d4d4d5_00000000_ffffffff;

  logic         clk = 1'b0;
  logic         rst, in_valid, out_ready, in_ready, out_valid, busy;
  logic [127:0] in_state, out_state;
`ifdef INV_MIX_SCHED_BYPASS_EN
  logic         in_bypass;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  inv_mix_cols_sched dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
`ifdef INV_MIX_SCHED_BYPASS_EN
    .in_bypass (in_bypass),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Counts cycles until out_valid is seen, capped at TMO.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < TMO) begin
      step();
      lat++;
    end
  endtask

  task automatic go_idle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_state = '0;
`ifdef INV_MIX_SCHED_BYPASS_EN
    in_bypass = 1'b0;
`endif
    step(); step();
    rst = 1'b0; #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    n_vec++; if (out_state !== 128'h0) begin n_err++; $display("FAIL rst_out_state got=%h exp=0", out_state); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", busy); end
  endtask

  task automatic test_transform(input logic [127:0] v, input logic [127:0] e, input string nm);
    int lat;
    in_state = v; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL %s_busy got=%b exp=1", nm, busy); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL %s_in_ready_busy got=%b exp=0", nm, in_ready); end
    wait_valid(lat);
    n_vec++; if (lat != EXP_LAT) begin n_err++; $display("FAIL %s_latency got=%0d exp=%0d", nm, lat, EXP_LAT); end
    n_vec++; if (out_state !== e) begin n_err++; $display("FAIL %s_out_state got=%h exp=%h", nm, out_state, e); end
    step();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL %s_valid_drop got=%b exp=0", nm, out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL %s_back_idle got=%b exp=1", nm, in_ready); end
  endtask

  task automatic test_back_to_back();
    int lat;
    in_state = V1; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_state = V2;
    wait_valid(lat);
    n_vec++; if (lat != EXP_LAT) begin n_err++; $display("FAIL hold_first_latency got=%0d exp=%0d", lat, EXP_LAT); end
    for (int i = 0; i < 10; i++) begin
      step();
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL hold_valid[%0d] got=%b exp=1", i, out_valid); end
      n_vec++; if (out_state !== E1) begin n_err++; $display("FAIL hold_state[%0d] got=%h exp=%h", i, out_state, E1); end
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL hold_in_ready[%0d] got=%b exp=0", i, in_ready); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL hold_no_accept[%0d] got=%b exp=0", i, busy); end
    end
    out_ready = 1'b1; #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_valid_drop got=%b exp=0", out_valid); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy got=%b exp=1", busy); end
    wait_valid(lat);
    n_vec++; if (lat != EXP_LAT) begin n_err++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, EXP_LAT); end
    n_vec++; if (out_state !== E2) begin n_err++; $display("FAIL b2b_state got=%h exp=%h", out_state, E2); end
    go_idle();
  endtask

  task automatic test_reset_mid_busy();
    int spurious;
    in_state = V1; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL abort_out_valid got=%b exp=0", out_valid); end
    n_vec++; if (out_state !== 128'h0) begin n_err++; $display("FAIL abort_out_state got=%h exp=0", out_state); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL abort_in_ready got=%b exp=1", in_ready); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%b exp=0", busy); end
    spurious = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid !== 1'b0 || busy !== 1'b0) spurious++;
    end
    n_vec++; if (spurious != 0) begin n_err++; $display("FAIL abort_spurious got=%0d exp=0", spurious); end
  endtask

  task automatic test_reset_vs_valid();
    rst = 1'b1; in_valid = 1'b1; in_state = V1; out_ready = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0; #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_wins_busy got=%b exp=0", busy); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_wins_ready got=%b exp=1", in_ready); end
    step();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_wins_later got=%b exp=0", busy); end
  endtask

  task automatic test_busy_ignore();
    int lat;
    in_state = V2; in_valid = 1'b1; out_ready = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      in_valid = (i % 2 == 0);
      in_state = {$urandom(), $urandom(), $urandom(), $urandom()};
      step();
    end
    in_valid = 1'b0;
    wait_valid(lat);
    n_vec++; if (lat != EXP_LAT - 3) begin n_err++; $display("FAIL ignore_latency got=%0d exp=%0d", lat, EXP_LAT - 3); end
    n_vec++; if (out_state !== E2) begin n_err++; $display("FAIL ignore_state got=%h exp=%h", out_state, E2); end
    go_idle();
  endtask

`ifdef INV_MIX_SCHED_BYPASS_EN
  task automatic test_bypass();
    int lat;
    in_state = V1; in_valid = 1'b1; in_bypass = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0; in_bypass = 1'b0;
    wait_valid(lat);
    n_vec++; if (lat != EXP_LAT) begin n_err++; $display("FAIL bypass_latency got=%0d exp=%0d", lat, EXP_LAT); end
    n_vec++; if (out_state !== V1) begin n_err++; $display("FAIL bypass_state got=%h exp=%h", out_state, V1); end
    go_idle();
  endtask
`endif

  initial begin
    test_reset();
    test_transform(V1, E1, "v1");
    test_transform(V2, E2, "v2");
    test_back_to_back();
    test_reset_mid_busy();
    test_reset_vs_valid();
    test_busy_ignore();
`ifdef INV_MIX_SCHED_BYPASS_EN
    test_bypass();
    test_transform(V1, E1, "v1_after_bypass");
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
